// File: rtl/scm_ctrl_pkg.sv
// Shared types and helpers for the SCM write-port scheduler.
// scm_wr_req_t uses the default register-file geometry (32 words x 32 bits).
package scm_ctrl_pkg;

  localparam int SCM_ADDR_W   = 5;
  localparam int SCM_DATA_W   = 32;
  localparam int SCM_RD_PORTS = 3;

  typedef struct packed {
    logic [SCM_ADDR_W-1:0] addr;
    logic [SCM_DATA_W-1:0] data;
  } scm_wr_req_t;

  // Next index in a ring of n requesters.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/scm_rr_pick2.sv
// Combinational two-winner round-robin picker. The first valid requester from
// ptr_i wins A; the next valid one wins B only when its address differs from A's.
import scm_ctrl_pkg::*;

module scm_rr_pick2 #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 5,
  parameter int IDX_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          en_i,
  input  logic [NUM_REQ-1:0]            valid_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] addr_i,
  input  logic [IDX_W-1:0]              ptr_i,
  output logic [IDX_W-1:0]              idx_a_o,
  output logic                          vld_a_o,
  output logic [IDX_W-1:0]              idx_b_o,
  output logic                          vld_b_o
);

  logic [ADDR_WIDTH-1:0] addr_arr [NUM_REQ];

  for (genvar r = 0; r < NUM_REQ; r++) begin : g_unpack
    assign addr_arr[r] = addr_i[r*ADDR_WIDTH +: ADDR_WIDTH];
  end

  // Only the second valid requester is a B candidate; a conflicting one
  // leaves B empty instead of letting a later requester jump the queue.
  always_comb begin
    logic [IDX_W-1:0] cand;
    logic [IDX_W-1:0] idx_a;
    logic [IDX_W-1:0] idx_b;
    logic             vld_a;
    logic             vld_b;
    logic             seen_second;
    cand        = ptr_i;
    idx_a       = '0;
    idx_b       = '0;
    vld_a       = 1'b0;
    vld_b       = 1'b0;
    seen_second = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (en_i && valid_i[cand]) begin
        if (!vld_a) begin
          vld_a = 1'b1;
          idx_a = cand;
        end else if (!seen_second) begin
          seen_second = 1'b1;
          if (addr_arr[cand] != addr_arr[idx_a]) begin
            vld_b = 1'b1;
            idx_b = cand;
          end
        end
      end
      cand = IDX_W'(rr_next(int'(cand), NUM_REQ));
    end
    idx_a_o = idx_a;
    vld_a_o = vld_a;
    idx_b_o = idx_b;
    vld_b_o = vld_b;
  end

endmodule

// File: rtl/scm_write_port_scheduler.sv
// Shares the two SCM write ports among NUM_REQ requesters, drives W1/W2 from
// registers one cycle after the grant, and flags reads of words in flight.
import scm_ctrl_pkg::*;

module scm_write_port_scheduler #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          sched_en_i,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  output logic                          we_a_o,
  output logic [ADDR_WIDTH-1:0]         waddr_a_o,
  output logic [DATA_WIDTH-1:0]         wdata_a_o,
  output logic                          we_b_o,
  output logic [ADDR_WIDTH-1:0]         waddr_b_o,
  output logic [DATA_WIDTH-1:0]         wdata_b_o,
  input  logic [ADDR_WIDTH-1:0]         raddr_a_i,
  input  logic [ADDR_WIDTH-1:0]         raddr_b_i,
  input  logic [ADDR_WIDTH-1:0]         raddr_c_i,
  output logic [SCM_RD_PORTS-1:0]       rd_stall_o
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } wr_port_t;

  logic [ADDR_WIDTH-1:0] addr_arr [NUM_REQ];
  logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];

  for (genvar r = 0; r < NUM_REQ; r++) begin : g_unpack
    assign addr_arr[r] = req_addr_i[r*ADDR_WIDTH +: ADDR_WIDTH];
    assign data_arr[r] = req_data_i[r*DATA_WIDTH +: DATA_WIDTH];
  end

  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic             we_a_q, we_b_q;
  wr_port_t         port_a_q, port_a_d;
  wr_port_t         port_b_q, port_b_d;

  logic             pick_en;
  logic [IDX_W-1:0] idx_a, idx_b;
  logic             vld_a, vld_b;

  // Handshake: requester r transfers in a cycle where req_valid_i[r] and
  // req_ready_o[r] are both high; it holds valid/addr/data stable until then,
  // and ready is never raised during reset or while scheduling is disabled.
  assign pick_en = sched_en_i & ~rst;

  scm_rr_pick2 #(
    .NUM_REQ   (NUM_REQ),
    .ADDR_WIDTH(ADDR_WIDTH),
    .IDX_W     (IDX_W)
  ) u_pick (
    .en_i   (pick_en),
    .valid_i(req_valid_i),
    .addr_i (req_addr_i),
    .ptr_i  (rr_ptr_q),
    .idx_a_o(idx_a),
    .vld_a_o(vld_a),
    .idx_b_o(idx_b),
    .vld_b_o(vld_b)
  );

  always_comb begin
    req_ready_o = '0;
    if (vld_a) req_ready_o[idx_a] = 1'b1;
    if (vld_b) req_ready_o[idx_b] = 1'b1;
  end

  // The pointer moves past the last winner so the skipped requester leads next.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (vld_b) begin
      rr_ptr_d = IDX_W'(rr_next(int'(idx_b), NUM_REQ));
    end else if (vld_a) begin
      rr_ptr_d = IDX_W'(rr_next(int'(idx_a), NUM_REQ));
    end
  end

  always_comb begin
    port_a_d = port_a_q;
    port_b_d = port_b_q;
    if (vld_a) begin
      port_a_d.addr = addr_arr[idx_a];
      port_a_d.data = data_arr[idx_a];
    end
    if (vld_b) begin
      port_b_d.addr = addr_arr[idx_b];
      port_b_d.data = data_arr[idx_b];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q <= '0;
      we_a_q   <= 1'b0;
      we_b_q   <= 1'b0;
      port_a_q <= '0;
      port_b_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      we_a_q   <= vld_a;
      we_b_q   <= vld_b;
      port_a_q <= port_a_d;
      port_b_q <= port_b_d;
    end
  end

  assign we_a_o    = we_a_q;
  assign waddr_a_o = port_a_q.addr;
  assign wdata_a_o = port_a_q.data;
  assign we_b_o    = we_b_q;
  assign waddr_b_o = port_b_q.addr;
  assign wdata_b_o = port_b_q.data;

  logic [ADDR_WIDTH-1:0] raddr_arr [SCM_RD_PORTS];
  assign raddr_arr[0] = raddr_a_i;
  assign raddr_arr[1] = raddr_b_i;
  assign raddr_arr[2] = raddr_c_i;

  // Compared against the registered ports: those are the writes the SCM
  // captures at the end of this cycle.
  for (genvar n = 0; n < SCM_RD_PORTS; n++) begin : g_stall
    assign rd_stall_o[n] = (we_a_q && (raddr_arr[n] == port_a_q.addr)) ||
                           (we_b_q && (raddr_arr[n] == port_b_q.addr));
  end

  a_b_needs_a: assert property (@(posedge clk) disable iff (rst) we_b_q |-> we_a_q);
  a_no_same_word: assert property (@(posedge clk) disable iff (rst)
    !(we_a_q && we_b_q && (port_a_q.addr == port_b_q.addr)));
  a_pick_distinct: assert property (@(posedge clk) disable iff (rst)
    vld_b |-> (vld_a && (addr_arr[idx_a] != addr_arr[idx_b])));

endmodule

// File: tb/tb_scm_write_port_scheduler.sv
// Directed bench for scm_write_port_scheduler: write-port scoreboard plus an
// SCM reference memory fed from the DUT write ports.
module tb_scm_write_port_scheduler;
  import scm_ctrl_pkg::*;

  localparam int NR = 4;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int EW = AW + DW;

  logic              clk;
  logic              rst;
  logic              sched_en;
  logic [NR-1:0]     req_valid;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*DW-1:0]  req_data;
  logic [NR-1:0]     req_ready;
  logic              we_a, we_b;
  logic [AW-1:0]     waddr_a, waddr_b;
  logic [DW-1:0]     wdata_a, wdata_b;
  logic [AW-1:0]     raddr_a, raddr_b, raddr_c;
  logic [2:0]        rd_stall;

  logic [EW-1:0]     exp_q[$];
  logic [DW-1:0]     scm_mem [32];
  int                checks;
  int                errors;

  scm_write_port_scheduler #(
    .NUM_REQ   (NR),
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sched_en_i (sched_en),
    .req_valid_i(req_valid),
    .req_addr_i (req_addr),
    .req_data_i (req_data),
    .req_ready_o(req_ready),
    .we_a_o     (we_a),
    .waddr_a_o  (waddr_a),
    .wdata_a_o  (wdata_a),
    .we_b_o     (we_b),
    .waddr_b_o  (waddr_b),
    .wdata_b_o  (wdata_b),
    .raddr_a_i  (raddr_a),
    .raddr_b_i  (raddr_b),
    .raddr_c_i  (raddr_c),
    .rd_stall_o (rd_stall)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic set_req(input int r, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_addr[r*AW +: AW] = a;
    req_data[r*DW +: DW] = d;
  endtask

  task automatic exp_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic sb_check(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] d);
    logic [EW-1:0] got;
    logic [EW-1:0] e;
    got = {a, d};
    checks++;
    assert (exp_q.size() > 0) else begin
      errors++;
      $error("FAIL %s_unexpected observed=%0h expected=none", tag, got);
    end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk(tag, 64'(got), 64'(e));
    end
  endtask

  // scoreboard and SCM reference model (W2 written last, so it wins)
  always @(negedge clk) begin
    if (we_a) sb_check("w1_write", waddr_a, wdata_a);
    if (we_b) sb_check("w2_write", waddr_b, wdata_b);
    chk("w2_without_w1", 64'(we_b & ~we_a), 64'(0));
    if (we_a) scm_mem[waddr_a] <= wdata_a;
    if (we_b) scm_mem[waddr_b] <= wdata_b;
  end

  initial begin
    checks    = 0;
    errors    = 0;
    for (int i = 0; i < 32; i++) scm_mem[i] = '0;
    rst       = 1'b1;
    sched_en  = 1'b1;
    req_valid = 4'b1111;
    req_addr  = '0;
    req_data  = '0;
    raddr_a   = 5'd31;
    raddr_b   = 5'd30;
    raddr_c   = 5'd29;
    set_req(0, 5'd1, 32'h0000_00A0);
    set_req(1, 5'd2, 32'h0000_00A1);
    set_req(2, 5'd3, 32'h0000_00A2);
    set_req(3, 5'd4, 32'h0000_00A3);
    next_cycle();

    // reset held with all requesters valid
    for (int i = 0; i < 2; i++) begin
      sample();
      chk("rst_ready", 64'(req_ready), 64'(0));
      chk("rst_we_a", 64'(we_a), 64'(0));
      chk("rst_we_b", 64'(we_b), 64'(0));
      chk("rst_stall", 64'(rd_stall), 64'(0));
      next_cycle();
    end
    rst = 1'b0;

    // C1..C4: all valid, distinct addresses
    sample();
    chk("c1_ready", 64'(req_ready), 64'(4'b0011));
    chk("c1_we_a", 64'(we_a), 64'(0));
    exp_wr(5'd1, 32'h0000_00A0);
    exp_wr(5'd2, 32'h0000_00A1);
    next_cycle();
    set_req(0, 5'd1, 32'h0000_00B0);
    set_req(1, 5'd2, 32'h0000_00B1);

    sample();
    chk("c2_ready", 64'(req_ready), 64'(4'b1100));
    exp_wr(5'd3, 32'h0000_00A2);
    exp_wr(5'd4, 32'h0000_00A3);
    next_cycle();
    set_req(2, 5'd3, 32'h0000_00B2);
    set_req(3, 5'd4, 32'h0000_00B3);
    raddr_a = 5'd5;
    raddr_b = 5'd4;
    raddr_c = 5'd3;

    sample();
    chk("c3_ready", 64'(req_ready), 64'(4'b0011));
    chk("c3_stall_two_ports", 64'(rd_stall), 64'(3'b110));
    exp_wr(5'd1, 32'h0000_00B0);
    exp_wr(5'd2, 32'h0000_00B1);
    next_cycle();
    set_req(0, 5'd1, 32'h0000_00C0);
    set_req(1, 5'd2, 32'h0000_00C1);
    raddr_a = 5'd31;
    raddr_b = 5'd30;
    raddr_c = 5'd29;

    sample();
    chk("c4_ready", 64'(req_ready), 64'(4'b1100));
    chk("c4_stall", 64'(rd_stall), 64'(0));
    exp_wr(5'd3, 32'h0000_00B2);
    exp_wr(5'd4, 32'h0000_00B3);
    next_cycle();
    req_valid = 4'b0001;

    // C5: single grant moves the pointer to 1
    sample();
    chk("c5_ready", 64'(req_ready), 64'(4'b0001));
    exp_wr(5'd1, 32'h0000_00C0);
    next_cycle();
    req_valid = 4'b0110;
    set_req(1, 5'd7, 32'h0000_00D1);
    set_req(2, 5'd7, 32'h0000_00D2);

    // C6/C7: same-word conflict, serialised in rr order
    sample();
    chk("c6_conflict_ready", 64'(req_ready), 64'(4'b0010));
    exp_wr(5'd7, 32'h0000_00D1);
    next_cycle();
    req_valid = 4'b0100;

    sample();
    chk("c7_ready", 64'(req_ready), 64'(4'b0100));
    chk("c7_we_a", 64'(we_a), 64'(1));
    chk("c7_waddr_a", 64'(waddr_a), 64'(7));
    chk("c7_we_b", 64'(we_b), 64'(0));
    exp_wr(5'd7, 32'h0000_00D2);
    next_cycle();
    req_valid = 4'b1000;
    set_req(3, 5'd3, 32'h0000_00E3);
    raddr_a = 5'd3;
    raddr_b = 5'd0;
    raddr_c = 5'd9;

    // C8..C10: read hazard on W1
    sample();
    chk("c8_ready", 64'(req_ready), 64'(4'b1000));
    chk("c8_stall", 64'(rd_stall), 64'(0));
    chk("c8_waddr_b_hold", 64'(waddr_b), 64'(4));
    exp_wr(5'd3, 32'h0000_00E3);
    next_cycle();
    req_valid = 4'b0000;
    raddr_b   = 5'd4;

    sample();
    chk("c9_ready", 64'(req_ready), 64'(0));
    chk("c9_stall_w1", 64'(rd_stall), 64'(3'b001));
    next_cycle();

    sample();
    chk("c10_stall", 64'(rd_stall), 64'(0));
    chk("c10_mem3", 64'(scm_mem[3]), 64'(32'h0000_00E3));
    chk("c10_mem4", 64'(scm_mem[4]), 64'(32'h0000_00B3));
    chk("c10_mem7", 64'(scm_mem[7]), 64'(32'h0000_00D2));
    next_cycle();
    req_valid = 4'b0010;
    set_req(1, 5'd10, 32'h0000_00F9);
    raddr_a = 5'd31;
    raddr_b = 5'd30;
    raddr_c = 5'd29;

    // C11..C15: scheduling disabled with requests held
    sample();
    chk("c11_ready", 64'(req_ready), 64'(4'b0010));
    exp_wr(5'd10, 32'h0000_00F9);
    next_cycle();
    sched_en  = 1'b0;
    req_valid = 4'b1111;
    set_req(0, 5'd1,  32'h0000_0F00);
    set_req(1, 5'd11, 32'h0000_0F01);
    set_req(2, 5'd12, 32'h0000_0F02);
    set_req(3, 5'd13, 32'h0000_0F03);

    sample();
    chk("c12_dis_ready", 64'(req_ready), 64'(0));
    chk("c12_inflight_we_a", 64'(we_a), 64'(1));
    next_cycle();
    for (int i = 0; i < 2; i++) begin
      sample();
      chk("dis_ready", 64'(req_ready), 64'(0));
      chk("dis_we_a", 64'(we_a), 64'(0));
      chk("dis_we_b", 64'(we_b), 64'(0));
      next_cycle();
    end
    sched_en = 1'b1;

    sample();
    chk("c15_resume_ready", 64'(req_ready), 64'(4'b1100));
    exp_wr(5'd12, 32'h0000_0F02);
    exp_wr(5'd13, 32'h0000_0F03);
    next_cycle();
    req_valid = 4'b0011;

    // C16..C20: reset while writes are registered
    sample();
    chk("c16_ready", 64'(req_ready), 64'(4'b0011));
    exp_wr(5'd1,  32'h0000_0F00);
    exp_wr(5'd11, 32'h0000_0F01);
    next_cycle();
    rst       = 1'b1;
    req_valid = 4'b1111;
    set_req(0, 5'd20, 32'h0000_0100);
    set_req(1, 5'd21, 32'h0000_0101);
    set_req(2, 5'd22, 32'h0000_0102);
    set_req(3, 5'd23, 32'h0000_0103);

    sample();
    chk("c17_rst_ready", 64'(req_ready), 64'(0));
    chk("c17_we_a", 64'(we_a), 64'(1));
    chk("c17_we_b", 64'(we_b), 64'(1));
    next_cycle();
    rst = 1'b0;

    sample();
    chk("c18_we_a", 64'(we_a), 64'(0));
    chk("c18_we_b", 64'(we_b), 64'(0));
    chk("c18_waddr_a", 64'(waddr_a), 64'(0));
    chk("c18_ready_ptr0", 64'(req_ready), 64'(4'b0011));
    chk("c18_mem22", 64'(scm_mem[22]), 64'(0));
    chk("c18_mem23", 64'(scm_mem[23]), 64'(0));
    chk("c18_mem1", 64'(scm_mem[1]), 64'(32'h0000_0F00));
    chk("c18_mem11", 64'(scm_mem[11]), 64'(32'h0000_0F01));
    exp_wr(5'd20, 32'h0000_0100);
    exp_wr(5'd21, 32'h0000_0101);
    next_cycle();
    req_valid = 4'b0000;

    sample();
    chk("c19_ready", 64'(req_ready), 64'(0));
    next_cycle();

    sample();
    chk("c20_mem20", 64'(scm_mem[20]), 64'(32'h0000_0100));
    chk("c20_mem21", 64'(scm_mem[21]), 64'(32'h0000_0101));
    chk("c20_mem22", 64'(scm_mem[22]), 64'(0));
    chk("c20_mem12", 64'(scm_mem[12]), 64'(32'h0000_0F02));
    chk("sb_drained", 64'(exp_q.size()), 64'(0));

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
